i2c_target_regfile: RTL and testbench
=====================================

// Module: i2c_target_regfile
// PURPOSE
//  Synthesizable I2C target (slave) holding a small byte register file. Sits directly downstream of the
//  i2c_master_wbs_16 bus pins: consumes the master's SCL/SDA and drives the wired-AND responder SDA/SCL.
//  Replaces the behavioural responder in the wb16 bench; the same RTL is reusable on FPGA as a loopback target.
// PARAMETERS
//  DEV_ADDR      7'h50  7-bit target address matched after START
//  NREGS         16     register-file depth in bytes (power of 2, 2..256)
//  FILTER_LEN    3      consecutive equal samples required before a synced SCL/SDA level is accepted
//  STRETCH_CYC   8      clk cycles SCL is held low after each ACK/NACK slot (only with I2C_TGT_STRETCH_EN)
// PORTS
//  clk        in   1               system clock, all logic on rising edge
//  rst        in   1               synchronous reset, active-low (0 = reset)
//  scl_i      in   1               bus SCL (wired-AND result)
//  sda_i      in   1               bus SDA (wired-AND result)
//  scl_o      out  1               open-drain SCL drive: 0 = pull low, 1 = release
//  sda_o      out  1               open-drain SDA drive: 0 = pull low, 1 = release
//  busy       out  1               1 from address-matched START until STOP/abort
//  wr_stb     out  1               one-cycle pulse when a data byte is written to the register file
//  wr_idx     out  $clog2(NREGS)   register index of current wr_stb
//  wr_dat     out  8               byte written with current wr_stb
// BEHAVIOUR
//  - Reset (rst=0 at clk edge): sda_o=1, scl_o=1, busy=0, wr_stb=0, wr_idx=0, wr_dat=0, all regs=8'h00, ptr=0,
//    FSM=IDLE. Reset mid-transfer releases the bus on the next edge; no partial byte is committed.
//  - Input path: 2-FF synchronizer, then FILTER_LEN majority-free filter (level changes only after FILTER_LEN equal
//    samples). Edges are detected on the filtered signals; latency from pin to edge detect = 2+FILTER_LEN clk.
//  - START: filtered SDA falls while SCL high -> FSM=ADDR, bit counter=7, from any state (repeated START included).
//    STOP: SDA rises while SCL high -> FSM=IDLE, busy=0, sda_o=1. START/STOP override any other event in that cycle.
//  - Sampling on filtered SCL rising edge; sda_o updated on the clk after filtered SCL falling edge.
//  - FSM states and transitions:
//    IDLE     : waits for START; sda_o=1.
//    ADDR     : shift 8 bits MSB-first. Addr==DEV_ADDR -> ADDR_ACK (busy=1); else -> IDLE (ignore until next START).
//    ADDR_ACK : drive 0 during 9th clock. R/W=0 -> PTR; R/W=1 -> RD_DATA (load shift reg from regs[ptr]).
//    PTR      : receive 8 bits, ptr <= byte mod NREGS -> PTR_ACK (ACK always) -> WR_DATA.
//    WR_DATA  : receive byte -> WR_ACK: regs[ptr]<=byte, wr_stb=1 for one clk on the 9th SCL rise, ptr++ -> WR_DATA.
//    RD_DATA  : drive 8 bits MSB-first -> RD_ACK: release SDA, sample master bit. ACK(0): ptr++, reload -> RD_DATA;
//               NACK(1): -> IDLE (busy remains 1 until STOP).
//  - ptr wraps NREGS-1 -> 0 on both read and write auto-increment. Pointer persists across transactions and
//    repeated START, so write-ptr + Sr + read returns regs[ptr].
//  - A general call (addr 0) is not matched. ptr byte >= NREGS is silently wrapped (mod NREGS), still ACKed.
//  - Without I2C_TGT_STRETCH_EN: scl_o is constant 1.
// CONFIGURATION
//  I2C_TGT_STRETCH_EN defined: after the SCL falling edge ending each ACK/NACK slot the block holds scl_o=0 for
//   STRETCH_CYC clk, then releases; START/STOP/reset release scl_o immediately. Not defined: no stretching logic.
// STRUCTURE
//  Package i2c_tgt_pkg: state enum typedef (IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK),
//   constants for R/W bit position and bits-per-byte.
//  Sub-module i2c_tgt_line_filter (one instance each for SCL and SDA): sync + filter + rise/fall pulses.
// TESTING
//  1 Write: START,A0(0x50 W),ptr 0x03,data 0xA5,0x5A,STOP -> 3 ACKs+data ACKs; wr_stb x2 idx 3/4; regs[3]=A5,[4]=5A.
//  2 Read w/ Sr: START,0xA0,ptr 0x03,Sr,0xA1, read 2 bytes ACK then NACK,STOP -> bytes A5,5A; busy 0 after STOP.
//  3 Wrap: write ptr 0x0F, data 11,22 -> regs[15]=11, regs[0]=22; ptr byte 0x13 selects reg 3.
//  4 Mismatch: START,0xA2 -> SDA released on 9th clock (NACK), no wr_stb, busy stays 0.
//  5 Abort: STOP mid data byte -> FSM IDLE, no write; rst=0 mid RD_DATA -> sda_o=1 next clk, regs all 00.
//  6 With I2C_TGT_STRETCH_EN: scl_o low exactly 8 clk after each ACK slot; master observes stretched SCL.

Source files
------------

// File: rtl/i2c_tgt_pkg.sv
// Shared types and constants for the I2C register-file target.
package i2c_tgt_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned RW_BIT_POS    = 0;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK
  } tgt_state_e;

  // Sub-phases of a 9th-bit slot: before it starts, while SCL is in the slot, after the slot's SCL rise
  typedef enum logic [1:0] {
    PH_PRE,
    PH_SLOT,
    PH_POST
  } ack_phase_e;

endpackage

// File: rtl/i2c_tgt_line_filter.sv
// Synchronizes one bus line, filters glitches and flags accepted level changes.
module i2c_tgt_line_filter #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          meta;
  logic          sync;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer, reset to the idle (released) bus level
  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive samples disagree with the current one
  always_ff @(posedge clk) begin
    if (!rst) begin
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync;
        cnt   <= '0;
        rise  <= sync;
        fall  <= ~sync;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a byte register file and auto-incrementing pointer.
// Optional clock stretching after each ACK/NACK slot: define I2C_TGT_STRETCH_EN.
module i2c_target_regfile
  import i2c_tgt_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h50,
  parameter int unsigned NREGS       = 16,
  parameter int unsigned FILTER_LEN  = 3,
  parameter int unsigned STRETCH_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     scl_i,
  input  logic                     sda_i,
  output logic                     scl_o,
  output logic                     sda_o,
  output logic                     busy,
  output logic                     wr_stb,
  output logic [$clog2(NREGS)-1:0] wr_idx,
  output logic [7:0]               wr_dat
);

  localparam int unsigned IW = $clog2(NREGS);
  localparam logic [2:0]  BIT_TOP = 3'(BITS_PER_BYTE - 1);

  // Elaboration-time parameter sanity
  if (NREGS < 2 || NREGS > 256 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
    $error("NREGS must be a power of 2 in 2..256");
  end
  if (FILTER_LEN < 1 || STRETCH_CYC < 1) begin : g_bad_len
    $error("FILTER_LEN and STRETCH_CYC must be at least 1");
  end

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_ev, stop_ev;
  logic [7:0] rx_byte;
  logic [IW-1:0] ptr_inc;

  tgt_state_e state;
  ack_phase_e phase;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic          rw;
  logic          mack;
  logic [IW-1:0] ptr;
  logic [7:0]    regs [NREGS];

  i2c_tgt_line_filter #(.FILTER_LEN(FILTER_LEN)) u_scl_filt (
    .clk(clk), .rst(rst), .pin(scl_i), .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_tgt_line_filter #(.FILTER_LEN(FILTER_LEN)) u_sda_filt (
    .clk(clk), .rst(rst), .pin(sda_i), .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_ev = sda_fall & scl_lvl;
  assign stop_ev  = sda_rise & scl_lvl;
  assign rx_byte  = {sh[6:0], sda_lvl};
  assign ptr_inc  = ptr + IW'(1);

  // Protocol FSM, register file and pointer; START/STOP take priority over bit events
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      phase  <= PH_PRE;
      bcnt   <= BIT_TOP;
      sh     <= '0;
      rw     <= 1'b0;
      mack   <= 1'b1;
      ptr    <= '0;
      sda_o  <= 1'b1;
      busy   <= 1'b0;
      wr_stb <= 1'b0;
      wr_idx <= '0;
      wr_dat <= '0;
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      wr_stb <= 1'b0;
      if (start_ev) begin
        state <= ADDR;
        phase <= PH_PRE;
        bcnt  <= BIT_TOP;
        sda_o <= 1'b1;
      end else if (stop_ev) begin
        state <= IDLE;
        busy  <= 1'b0;
        sda_o <= 1'b1;
      end else begin
        case (state)
          IDLE: sda_o <= 1'b1;

          ADDR: if (scl_rise) begin
            sh <= rx_byte;
            if (bcnt != 3'd0) begin
              bcnt <= bcnt - 3'd1;
            end else if (rx_byte[7:1] == DEV_ADDR && rx_byte[7:1] != 7'h00) begin
              state <= ADDR_ACK;
              phase <= PH_PRE;
              busy  <= 1'b1;
              rw    <= rx_byte[RW_BIT_POS];
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end

          PTR, WR_DATA: if (scl_rise) begin
            sh <= rx_byte;
            if (bcnt != 3'd0) begin
              bcnt <= bcnt - 3'd1;
            end else begin
              state <= (state == PTR) ? PTR_ACK : WR_ACK;
              phase <= PH_PRE;
            end
          end

          ADDR_ACK, PTR_ACK, WR_ACK: begin
            if (phase == PH_PRE && scl_fall) begin
              sda_o <= 1'b0;
              phase <= PH_SLOT;
            end else if (phase == PH_SLOT && scl_rise) begin
              phase <= PH_POST;
              if (state == PTR_ACK) begin
                ptr <= IW'(sh);
              end else if (state == WR_ACK) begin
                regs[ptr] <= sh;
                wr_stb    <= 1'b1;
                wr_idx    <= ptr;
                wr_dat    <= sh;
                ptr       <= ptr_inc;
              end
            end else if (phase == PH_POST && scl_fall) begin
              bcnt <= BIT_TOP;
              if (state == ADDR_ACK && rw) begin
                state <= RD_DATA;
                sh    <= regs[ptr];
                sda_o <= regs[ptr][7];
              end else begin
                state <= (state == ADDR_ACK) ? PTR : WR_DATA;
                sda_o <= 1'b1;
              end
            end
          end

          RD_DATA: begin
            if (scl_fall) begin
              sda_o <= sh[6];
              sh    <= {sh[6:0], 1'b0};
            end else if (scl_rise) begin
              if (bcnt != 3'd0) begin
                bcnt <= bcnt - 3'd1;
              end else begin
                state <= RD_ACK;
                phase <= PH_PRE;
              end
            end
          end

          RD_ACK: begin
            if (phase == PH_PRE && scl_fall) begin
              sda_o <= 1'b1;
              phase <= PH_SLOT;
            end else if (phase == PH_SLOT && scl_rise) begin
              mack  <= sda_lvl;
              phase <= PH_POST;
            end else if (phase == PH_POST && scl_fall) begin
              if (!mack) begin
                ptr   <= ptr_inc;
                sh    <= regs[ptr_inc];
                sda_o <= regs[ptr_inc][7];
                bcnt  <= BIT_TOP;
                state <= RD_DATA;
              end else begin
                state <= IDLE;
              end
            end
          end

          default: begin
            state <= IDLE;
            sda_o <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef I2C_TGT_STRETCH_EN
  localparam int unsigned SW = $clog2(STRETCH_CYC + 1);

  logic          slot_end;
  logic [SW-1:0] st_cnt;

  assign slot_end = scl_fall && (phase == PH_POST) &&
                    (state inside {ADDR_ACK, PTR_ACK, WR_ACK, RD_ACK});

  // Hold SCL low for STRETCH_CYC clocks after each ACK/NACK slot ends
  always_ff @(posedge clk) begin
    if (!rst) begin
      scl_o  <= 1'b1;
      st_cnt <= '0;
    end else if (start_ev || stop_ev) begin
      scl_o  <= 1'b1;
      st_cnt <= '0;
    end else if (slot_end) begin
      scl_o  <= 1'b0;
      st_cnt <= SW'(STRETCH_CYC - 1);
    end else if (!scl_o) begin
      if (st_cnt == '0) scl_o <= 1'b1;
      else              st_cnt <= st_cnt - SW'(1);
    end
  end
`else
  assign scl_o = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged master, vector table plus corner-case sequences.
module tb_i2c_target_regfile;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       bus_scl, bus_sda;
  logic       scl_o, sda_o, busy, wr_stb;
  logic [3:0] wr_idx;
  logic [7:0] wr_dat;

  int checks = 0;
  int errors = 0;

  logic [3:0] stb_idx_q[$];
  logic [7:0] stb_dat_q[$];

  i2c_target_regfile dut (
    .clk(clk), .rst(rst), .scl_i(bus_scl), .sda_i(bus_sda),
    .scl_o(scl_o), .sda_o(sda_o), .busy(busy),
    .wr_stb(wr_stb), .wr_idx(wr_idx), .wr_dat(wr_dat)
  );

  always #5 clk = ~clk;

  assign bus_scl = scl_m & scl_o;
  assign bus_sda = sda_m & sda_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Capture every write strobe
  always @(negedge clk) begin
    if (wr_stb === 1'b1) begin
      stb_idx_q.push_back(wr_idx);
      stb_dat_q.push_back(wr_dat);
    end
  end

`ifdef I2C_TGT_STRETCH_EN
  int low_run = 0;
  // Each stretch episode must last exactly 8 clocks
  always @(negedge clk) begin
    if (scl_o === 1'b0) low_run++;
    else if (low_run != 0) begin
      chk("stretch_len", low_run, 8);
      low_run = 0;
    end
  end
`endif

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic scl_high();
    int n = 0;
    scl_m = 1'b1;
    while (bus_scl !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk("scl_release_timeout", bus_scl, 1);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; wait_clk(Q);
    scl_high();   wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wait_clk(Q);
    scl_high();   wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    sda_m = b;    wait_clk(Q);
    scl_high();   wait_clk(Q);
    s = bus_sda;
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], d);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    logic d;
    for (int i = 7; i >= 0; i--) clock_bit(1'b1, b[i]);
    clock_bit(ack_bit, d);
  endtask

  // Full write of one data byte: START, A0, ptr, data, STOP
  task automatic wr_txn(input logic [7:0] p, input logic [7:0] d, output logic [2:0] acks);
    start_cond();
    write_byte(8'hA0, acks[2]);
    write_byte(p, acks[1]);
    write_byte(d, acks[0]);
    stop_cond();
  endtask

  // Single-byte read: START, A0, ptr, Sr, A1, read with NACK, STOP
  task automatic rd_txn(input logic [7:0] p, output logic [7:0] d, output logic [2:0] acks);
    start_cond();
    write_byte(8'hA0, acks[2]);
    write_byte(p, acks[1]);
    start_cond();
    write_byte(8'hA1, acks[0]);
    read_byte(1'b1, d);
    stop_cond();
  endtask

  typedef struct {
    logic       is_wr;
    logic [7:0] ptr_b;
    logic [7:0] dat;
    logic [3:0] exp_idx;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [2:0] acks;
    logic [7:0] rd;
    logic       a;

    vecs[0] = '{1'b1, 8'h07, 8'h3C, 4'h7, 8'h00};
    vecs[1] = '{1'b1, 8'h1A, 8'hC3, 4'hA, 8'h00};
    vecs[2] = '{1'b0, 8'h07, 8'h00, 4'h0, 8'h3C};
    vecs[3] = '{1'b0, 8'h2A, 8'h00, 4'h0, 8'hC3};
    vecs[4] = '{1'b0, 8'h05, 8'h00, 4'h0, 8'h00};
    vecs[5] = '{1'b1, 8'hFF, 8'h96, 4'hF, 8'h00};
    vecs[6] = '{1'b0, 8'h0F, 8'h00, 4'h0, 8'h96};

    // Reset state
    rst = 1'b0;
    wait_clk(5);
    chk("rst_sda_o", sda_o, 1);
    chk("rst_scl_o", scl_o, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_stb", wr_stb, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_dat", wr_dat, 0);
    rst = 1'b1;
    wait_clk(10);

    // Vector table
    for (int v = 0; v < 7; v++) begin
      stb_idx_q.delete();
      stb_dat_q.delete();
      if (vecs[v].is_wr) begin
        wr_txn(vecs[v].ptr_b, vecs[v].dat, acks);
        chk($sformatf("vec%0d_acks", v), acks, 0);
        chk($sformatf("vec%0d_stb_cnt", v), stb_idx_q.size(), 1);
        if (stb_idx_q.size() == 1) begin
          chk($sformatf("vec%0d_wr_idx", v), stb_idx_q[0], vecs[v].exp_idx);
          chk($sformatf("vec%0d_wr_dat", v), stb_dat_q[0], vecs[v].dat);
        end
      end else begin
        rd_txn(vecs[v].ptr_b, rd, acks);
        chk($sformatf("vec%0d_acks", v), acks, 0);
        chk($sformatf("vec%0d_rd", v), rd, vecs[v].exp_rd);
        chk($sformatf("vec%0d_no_stb", v), stb_idx_q.size(), 0);
      end
    end

    // Two-byte write at ptr 3
    stb_idx_q.delete(); stb_dat_q.delete();
    start_cond();
    write_byte(8'hA0, acks[2]);
    chk("t1_busy_after_addr", busy, 1);
    write_byte(8'h03, acks[1]);
    write_byte(8'hA5, acks[0]);
    write_byte(8'h5A, a);
    stop_cond();
    chk("t1_acks", {acks, a}, 0);
    chk("t1_busy_after_stop", busy, 0);
    chk("t1_stb_cnt", stb_idx_q.size(), 2);
    if (stb_idx_q.size() == 2) begin
      chk("t1_idx0", stb_idx_q[0], 3);
      chk("t1_dat0", stb_dat_q[0], 8'hA5);
      chk("t1_idx1", stb_idx_q[1], 4);
      chk("t1_dat1", stb_dat_q[1], 8'h5A);
    end

    // Read two bytes after repeated START
    start_cond();
    write_byte(8'hA0, acks[2]);
    write_byte(8'h03, acks[1]);
    start_cond();
    write_byte(8'hA1, acks[0]);
    read_byte(1'b0, rd);
    chk("t2_rd0", rd, 8'hA5);
    read_byte(1'b1, rd);
    chk("t2_rd1", rd, 8'h5A);
    chk("t2_busy_after_nack", busy, 1);
    stop_cond();
    chk("t2_acks", acks, 0);
    chk("t2_busy_after_stop", busy, 0);

    // Pointer wrap on write, then read back across the wrap
    stb_idx_q.delete(); stb_dat_q.delete();
    start_cond();
    write_byte(8'hA0, acks[2]);
    write_byte(8'h0F, acks[1]);
    write_byte(8'h11, acks[0]);
    write_byte(8'h22, a);
    stop_cond();
    chk("t3_acks", {acks, a}, 0);
    chk("t3_stb_cnt", stb_idx_q.size(), 2);
    if (stb_idx_q.size() == 2) begin
      chk("t3_idx0", stb_idx_q[0], 15);
      chk("t3_idx1", stb_idx_q[1], 0);
    end
    start_cond();
    write_byte(8'hA0, acks[2]);
    write_byte(8'h0F, acks[1]);
    start_cond();
    write_byte(8'hA1, acks[0]);
    read_byte(1'b0, rd);
    chk("t3_rd15", rd, 8'h11);
    read_byte(1'b1, rd);
    chk("t3_rd0_wrapped", rd, 8'h22);
    stop_cond();
    rd_txn(8'h13, rd, acks);
    chk("t3_ptr13_acks", acks, 0);
    chk("t3_ptr13_rd", rd, 8'hA5);

    // Address mismatch and general call are not acknowledged
    stb_idx_q.delete();
    start_cond();
    write_byte(8'hA2, a);
    chk("t4_mismatch_nack", a, 1);
    chk("t4_busy", busy, 0);
    write_byte(8'h77, a);
    stop_cond();
    start_cond();
    write_byte(8'h00, a);
    chk("t4_gcall_nack", a, 1);
    stop_cond();
    chk("t4_no_stb", stb_idx_q.size(), 0);

    // STOP in the middle of a data byte commits nothing
    stb_idx_q.delete();
    start_cond();
    write_byte(8'hA0, acks[2]);
    write_byte(8'h05, acks[1]);
    clock_bit(1'b1, a);
    clock_bit(1'b0, a);
    clock_bit(1'b1, a);
    clock_bit(1'b1, a);
    stop_cond();
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_no_stb", stb_idx_q.size(), 0);
    rd_txn(8'h05, rd, acks);
    chk("t5_abort_reg5", rd, 8'h00);

    // Reset while the target is driving a 0 data bit
    start_cond();
    write_byte(8'hA0, acks[2]);
    write_byte(8'h03, acks[1]);
    start_cond();
    write_byte(8'hA1, acks[0]);
    clock_bit(1'b1, a);
    chk("t5_rd_bit7", a, 1);
    chk("t5_driving_bit6", sda_o, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_sda_release", sda_o, 1);
    chk("t5_rst_busy", busy, 0);
    rst = 1'b1;
    wait_clk(10);
    stop_cond();
    rd_txn(8'h03, rd, acks);
    chk("t5_post_rst_acks", acks, 0);
    chk("t5_post_rst_reg3", rd, 8'h00);
    rd_txn(8'h0F, rd, acks);
    chk("t5_post_rst_reg15", rd, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hang guard
  initial begin
    #(1_500_000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
